// File: rtl/alu_seq.sv
// Sequential ALU: one-cycle ops, WIDTH-cycle shift-add multiply and restoring divide; done/res land one edge after FIN.
// Latency 1 cycle (MUL/DIV: WIDTH+1); start is only sampled while busy=0, otherwise dropped.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             dz
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [1:0]       state;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc, sreg, dreg;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] alu_res, fin_res;
    logic             fin_dz;
    logic [SHW-1:0]   amt;
    logic             big;
    logic [WIDTH:0]   rem_sh, trial;

    function automatic logic [WIDTH-1:0] ext(input logic f);
        return {{(WIDTH-1){1'b0}}, f};
    endfunction

    assign busy   = (state != IDLE);
    assign amt    = a_q[SHW-1:0];
    assign big    = |a_q[WIDTH-1:SHW];
    // Divider: shift next dividend bit into the partial remainder, keep the trial subtraction if it did not borrow.
    assign rem_sh = {acc, sreg[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dreg};

    always_comb begin
        alu_res = a_q;
        case (op_q)
            5'h00: alu_res = b_q + a_q;
            5'h01: alu_res = b_q - a_q;
            5'h03: alu_res = b_q | a_q;
            5'h04: alu_res = b_q ^ a_q;
            5'h05: alu_res = b_q & a_q;
            5'h06: alu_res = big ? {WIDTH{b_q[WIDTH-1]}} : WIDTH'($signed(b_q) >>> amt);
            5'h07: alu_res = big ? '0 : (b_q >> amt);
            5'h08: alu_res = big ? '0 : (b_q << amt);
            5'h09: alu_res = -a_q;
            5'h0a: alu_res = ext(a_q == '0);
            5'h0b: alu_res = ~a_q;
            5'h0c: alu_res = ext(a_q != '0);
            5'h0d: alu_res = ext(b_q == a_q);
            5'h0e: alu_res = ext(b_q != a_q);
            5'h0f: alu_res = ext($signed(b_q) < $signed(a_q));
            5'h10: alu_res = ext(b_q < a_q);
            5'h11: alu_res = ext($signed(b_q) <= $signed(a_q));
            5'h12: alu_res = ext(b_q <= a_q);
            5'h13: alu_res = {{(WIDTH/2){a_q[WIDTH/2-1]}}, a_q[WIDTH/2-1:0]};
            5'h14: alu_res = b_q;
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        fin_dz = ((op_q == 5'h15) || (op_q == 5'h16)) && (a_q == '0);
        case (op_q)
            5'h02:   fin_res = acc;
            5'h15:   fin_res = (a_q == '0) ? '1 : sreg;
            5'h16:   fin_res = (a_q == '0) ? b_q : acc;
            default: fin_res = alu_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            sreg  <= '0;
            dreg  <= '0;
            cnt   <= '0;
            res   <= '0;
            done  <= 1'b0;
            zero  <= 1'b1;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= '0;
                        sreg <= b;
                        dreg <= a;
                        cnt  <= '0;
                        if (op == 5'h02)
                            state <= MUL;
                        else if (((op == 5'h15) || (op == 5'h16)) && (a != '0))
                            state <= DIV;
                        else
                            state <= FIN;
                    end
                end
                MUL: begin
                    acc  <= acc + (dreg[0] ? sreg : '0);
                    sreg <= sreg << 1;
                    dreg <= dreg >> 1;
                    cnt  <= cnt + SHW'(1);
                    if (cnt == LAST)
                        state <= FIN;
                end
                DIV: begin
                    if (!trial[WIDTH]) begin
                        acc  <= trial[WIDTH-1:0];
                        sreg <= {sreg[WIDTH-2:0], 1'b1};
                    end else begin
                        acc  <= rem_sh[WIDTH-1:0];
                        sreg <= {sreg[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + SHW'(1);
                    if (cnt == LAST)
                        state <= FIN;
                end
                FIN: begin
                    res   <= fin_res;
                    zero  <= (fin_res == '0);
                    dz    <= fin_dz;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=16): directed vectors, random ops against an arithmetic model, handshake scenarios.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, zero, dz;
    logic [15:0] res;

    int n_chk  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res(res), .zero(zero), .dz(dz)
    );

    always #5 clk = ~clk;

    // Returns {dz, res} from the opcode definitions using integer arithmetic.
    function automatic logic [16:0] ref_model(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y);
        int unsigned    ua = x;
        int unsigned    ub = y;
        int             sa = int'($signed(x));
        int             sb = int'($signed(y));
        int             sh = (ua > 15) ? 16 : int'(ua);
        logic signed [7:0] lo;
        logic [31:0]    r;
        logic           d;
        lo = x[7:0];
        d  = 1'b0;
        case (o)
            5'h00: r = ub + ua;
            5'h01: r = ub - ua;
            5'h02: r = ub * ua;
            5'h03: r = ub | ua;
            5'h04: r = ub ^ ua;
            5'h05: r = ub & ua;
            5'h06: r = sb >>> sh;
            5'h07: r = ub >> sh;
            5'h08: r = ub << sh;
            5'h09: r = 0 - ua;
            5'h0a: r = (ua == 0);
            5'h0b: r = ~ua;
            5'h0c: r = (ua != 0);
            5'h0d: r = (ub == ua);
            5'h0e: r = (ub != ua);
            5'h0f: r = (sb < sa);
            5'h10: r = (ub < ua);
            5'h11: r = (sb <= sa);
            5'h12: r = (ub <= ua);
            5'h13: r = lo;
            5'h14: r = ub;
            5'h15: begin
                if (ua == 0) begin r = 32'hFFFF; d = 1'b1; end
                else r = ub / ua;
            end
            5'h16: begin
                if (ua == 0) begin r = ub; d = 1'b1; end
                else r = ub % ua;
            end
            default: r = ua;
        endcase
        return {d, r[15:0]};
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [15:0] x);
        return (o == 5'h02 || ((o == 5'h15 || o == 5'h16) && x != 0)) ? 17 : 1;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Issue one op, scramble inputs while busy, return what the DUT reported on done.
    task automatic do_op(input logic [4:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic z, output logic d, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 5'($urandom); a = 16'($urandom); b = 16'($urandom);
        lat = 1;
        @(posedge clk); #1;
        if (!done) begin
            wait_done(lat);
            lat = lat + 1;
        end
        r = res; z = zero; d = dz;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (res !== 16'h0) begin n_fail++; $display("FAIL reset_res got=%h want=0000", res); end
        n_chk++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b want=1", zero); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_chk++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b want=0", dz); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || res !== 16'h0)
            begin n_fail++; $display("FAIL post_reset busy=%b done=%b res=%h want 0/0/0000", busy, done, res); end
    endtask

    task automatic test_directed;
        logic [4:0]  t_op [17] = '{5'h00, 5'h01, 5'h02, 5'h15, 5'h16, 5'h15, 5'h16, 5'h06, 5'h08,
                                   5'h07, 5'h06, 5'h0f, 5'h10, 5'h13, 5'h0a, 5'h1f, 5'h09};
        logic [15:0] t_b  [17] = '{16'hFFFF, 16'd5, 16'h0123, 16'd100, 16'd100, 16'd100, 16'd100, 16'h8000, 16'h0001,
                                   16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234, 16'h0001, 16'h0000};
        logic [15:0] t_a  [17] = '{16'h0002, 16'd5, 16'h0010, 16'd7, 16'd7, 16'd0, 16'd0, 16'h0004, 16'h0010,
                                   16'd15, 16'h0100, 16'h0001, 16'h0001, 16'h0080, 16'h0000, 16'hABCD, 16'h0001};
        logic [15:0] t_r  [17] = '{16'h0001, 16'h0000, 16'h1230, 16'd14, 16'd2, 16'hFFFF, 16'd100, 16'hF800, 16'h0000,
                                   16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 16'hFF80, 16'h0001, 16'hABCD, 16'hFFFF};
        int          t_l  [17] = '{1, 1, 17, 17, 17, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic        t_d  [17] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [15:0] r;
        logic        z, d;
        int          lat;
        for (int i = 0; i < 17; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], r, z, d, lat);
            n_chk++; if (r !== t_r[i]) begin n_fail++; $display("FAIL dir%0d_res op=%h got=%h want=%h", i, t_op[i], r, t_r[i]); end
            n_chk++; if (z !== (t_r[i] == 16'h0)) begin n_fail++; $display("FAIL dir%0d_zero got=%b want=%b", i, z, t_r[i] == 16'h0); end
            n_chk++; if (d !== t_d[i]) begin n_fail++; $display("FAIL dir%0d_dz got=%b want=%b", i, d, t_d[i]); end
            n_chk++; if (lat != t_l[i]) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, t_l[i]); end
        end
    endtask

    task automatic test_random;
        logic [4:0]  o;
        logic [15:0] x, y, r;
        logic [16:0] exp;
        logic        z, d;
        int          lat;
        for (int i = 0; i < 250; i++) begin
            o = 5'($urandom_range(0, 31));
            x = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            y = 16'($urandom);
            exp = ref_model(o, x, y);
            do_op(o, x, y, r, z, d, lat);
            n_chk++; if (r !== exp[15:0]) begin n_fail++; $display("FAIL rnd_res op=%h a=%h b=%h got=%h want=%h", o, x, y, r, exp[15:0]); end
            n_chk++; if (z !== (exp[15:0] == 16'h0)) begin n_fail++; $display("FAIL rnd_zero op=%h got=%b want=%b", o, z, exp[15:0] == 16'h0); end
            n_chk++; if (d !== exp[16]) begin n_fail++; $display("FAIL rnd_dz op=%h a=%h got=%b want=%b", o, x, d, exp[16]); end
            n_chk++; if (lat != ref_lat(o, x)) begin n_fail++; $display("FAIL rnd_latency op=%h got=%0d want=%0d", o, lat, ref_lat(o, x)); end
        end
    endtask

    task automatic test_ignore_start;
        int busy_cnt = 0;
        int cyc = 0;
        int extra = 0;
        @(negedge clk);
        start = 1'b1; op = 5'h02; a = 16'h0010; b = 16'h0123;
        @(posedge clk); #1;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            start = 1'b1; op = 5'h00; a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        n_chk++; if (res !== 16'h1230) begin n_fail++; $display("FAIL ignore_res got=%h want=1230", res); end
        n_chk++; if (busy_cnt != 17) begin n_fail++; $display("FAIL ignore_busy_cycles got=%0d want=17", busy_cnt); end
        n_chk++; if (cyc != 17) begin n_fail++; $display("FAIL ignore_latency got=%0d want=17", cyc); end
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        n_chk++; if (extra != 0) begin n_fail++; $display("FAIL ignore_not_queued got=%0d active cycles want=0", extra); end
    endtask

    task automatic test_reset_abort;
        int dones = 0;
        @(negedge clk);
        start = 1'b1; op = 5'h02; a = 16'h0003; b = 16'h0007;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_chk++; if (res !== 16'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL abort_res got=%h/%b want=0000/1", res, zero); end
        @(negedge clk); rst = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        n_chk++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done got=%0d pulses want=0", dones); end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  ops [8] = '{5'h02, 5'h00, 5'h15, 5'h0b, 5'h16, 5'h15, 5'h02, 5'h13};
        logic [15:0] xs [8];
        logic [15:0] ys [8];
        logic [16:0] exp;
        int          cyc;
        for (int i = 0; i < 8; i++) begin
            xs[i] = (i == 5) ? 16'h0 : 16'($urandom_range(1, 65535));
            ys[i] = 16'($urandom);
        end
        @(negedge clk);
        start = 1'b1; op = ops[0]; a = xs[0]; b = ys[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_done(cyc);
            cyc = cyc;
            exp = ref_model(ops[i], xs[i], ys[i]);
            n_chk++; if (res !== exp[15:0] || dz !== exp[16])
                begin n_fail++; $display("FAIL b2b%0d_res op=%h got=%h/%b want=%h/%b", i, ops[i], res, dz, exp[15:0], exp[16]); end
            n_chk++; if (cyc != ref_lat(ops[i], xs[i]))
                begin n_fail++; $display("FAIL b2b%0d_latency got=%0d want=%0d", i, cyc, ref_lat(ops[i], xs[i])); end
            if (i < 7) begin
                start = 1'b1; op = ops[i+1]; a = xs[i+1]; b = ys[i+1];
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, posedge-clocked successor to the processor ALU.
- Keeps the existing 5-bit opcode map: 0x00–0x14 have the same meaning as today.
- Adds iterative multiply, unsigned divide/modulo, a start/busy/done handshake and status flags, so the micro-sequencer can stall on multi-cycle operations.
- Sits between the register-file read ports and the result bus.

Parameters:
- WIDTH, 16, datapath width in bits; even, ≥4.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from a.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  5  opcode, captured with start.
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when res is updated.
- res  out  WIDTH  result; holds its value until the next done.
- zero  out  1  res==0, updated with done.
- dz  out  1  divide or modulo by zero on the last operation, updated with done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; res=0, busy=0, done=0, zero=1, dz=0; multiplier/divider registers cleared. Asserting rst mid-operation aborts it; no done is produced.
- States: IDLE, MUL, DIV, FIN.
- IDLE, start=1:
  - Latch op, a, b.
  - op 0x02 → MUL; op 0x15/0x16 → DIV; any other op → FIN.
  - busy=1 from the next cycle.
- IDLE, start=0: stay in IDLE.
- start while busy=1: ignored and not queued.
- Single-cycle ops:
  - start sampled at edge N; res, zero, dz and done=1 valid after edge N+1.
  - busy is high for exactly one cycle (FIN).
- FIN: drive done=1 for one cycle, then return to IDLE (busy=0).
  - start may be asserted in the same cycle done=1; it is accepted on the following edge, when busy=0.
- MUL (0x02):
  - Shift-add over WIDTH cycles, then FIN.
  - start→done = WIDTH+1 cycles.
  - Result is the low WIDTH bits of b*a.
- DIV:
  - Restoring divide, b ÷ a unsigned, over WIDTH cycles, then FIN.
  - 0x15 gives the quotient; 0x16 gives the remainder.
  - a==0: no iteration. Go straight to FIN with dz=1; res = all-ones for 0x15, res = b for 0x16. Latency is 1 cycle.
- dz=0 for every operation except a divide or modulo by zero.
- Opcode map (b is the left operand):
  - 0x00 b+a; 0x01 b-a; 0x03 b|a; 0x04 b^a; 0x05 b&a.
  - 0x06 arithmetic right shift; 0x07 logical right shift; 0x08 left shift.
  - 0x09 -a; 0x0a logical-not a (1 if a==0, else 0); 0x0b ~a; 0x0c (a!=0).
  - 0x0d b==a; 0x0e b!=a; 0x0f signed b<a; 0x10 unsigned b<a; 0x11 signed b<=a; 0x12 unsigned b<=a.
  - 0x13 sign-extend a[WIDTH/2-1:0]; 0x14 b.
  - 0x17–0x1f: res = a.
- Shift amount is a[SHW-1:0]. If any bit of a above SHW-1 is set, the amount is treated as ≥WIDTH:
  - 0x07 and 0x08 give 0.
  - 0x06 gives all copies of b[WIDTH-1].
- Comparisons and 0x0a/0x0c are zero-extended to WIDTH.
- Add, subtract and negate wrap modulo 2^WIDTH.
- Operands are captured at start; changing a, b or op while busy has no effect.

Test Plan:
- Reset then release → res=0, zero=1, busy=0, done=0. Assert rst during a MUL → busy=0 immediately, no done pulse.
- WIDTH=16: op 0x00, b=0xFFFF, a=0x0002 → done 1 cycle after start, res=0x0001, zero=0. op 0x01, b=5, a=5 → res=0, zero=1.
- op 0x02, b=0x0123, a=0x0010 → busy for 17 cycles, done at cycle 17, res=0x1230. Extra start pulses while busy are ignored.
- op 0x15, b=100, a=7 → res=14 after 17 cycles. op 0x16 → res=2. op 0x15 with a=0 → dz=1, res=0xFFFF, 1-cycle latency.
- Shifts: op 0x06, b=0x8000, a=0x0004 → 0xF800. op 0x08, b=1, a=0x0010 → 0. op 0x07, b=0x8000, a=15 → 1.
- Compare/extend: op 0x0f, b=0xFFFF, a=1 → 1. op 0x10, same operands → 0. op 0x13, a=0x0080 → 0xFF80. Back-to-back starts, each asserted on its done cycle → every op completes in order.
